seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 94 +++++++++
 tb/tb_seq_multiplier.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle unsigned shift-and-add multiplier producing a HI/LO product pair
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH:0]   prod_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     upper_next;
    logic [2*WIDTH:0]   prod_d;

    // prod_q[2W] is always zero entering an iteration, so the unchanged upper
    // field can be taken straight from the register.
    always_comb begin
        add_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        upper_next = prod_q[0] ? add_sum : prod_q[2*WIDTH:WIDTH];
        prod_d     = {1'b0, upper_next, prod_q[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        mcand_q <= i_data1;
                        prod_q  <= {1'b0, {WIDTH{1'b0}}, i_data2};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q    <= prod_d[WIDTH-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=32
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        s4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [3:0]  hi4, lo4;

    logic        s32;
    logic [31:0] a32, b32;
    logic        busy32, done32;
    logic [31:0] hi32, lo32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (s4),
        .i_data1 (a4),
        .i_data2 (b4),
        .o_busy  (busy4),
        .o_done  (done4),
        .o_hi    (hi4),
        .o_lo    (lo4)
    );

    seq_multiplier #(.WIDTH(32)) u_dut32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (s32),
        .i_data1 (a32),
        .i_data2 (b32),
        .o_busy  (busy32),
        .o_done  (done32),
        .o_hi    (hi32),
        .o_lo    (lo32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ehi, input logic [3:0] elo, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        s4 = 1'b1; a4 = a; b4 = b;
        @(posedge clk); #1;
        s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        busy_cnt = busy4 ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done4) seen = 1'b1;
            if (busy4) busy_cnt++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
        check({tag, "_hi"}, 64'(hi4), 64'(ehi));
        check({tag, "_lo"}, 64'(lo4), 64'(elo));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done4), 64'd0);
    endtask

    task automatic wait_done32(output int lat);
        bit seen;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done32) seen = 1'b1;
        end
    endtask

    task automatic mul32(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] eprod, input string tag);
        int lat;
        @(negedge clk);
        s32 = 1'b1; a32 = a; b32 = b;
        @(posedge clk); #1;
        s32 = 1'b0; a32 = $urandom; b32 = $urandom;
        check({tag, "_busy"}, 64'(busy32), 64'd1);
        wait_done32(lat);
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_hi"}, 64'(hi32), 64'(eprod[63:32]));
        check({tag, "_lo"}, 64'(lo32), 64'(eprod[31:0]));
    endtask

    initial begin
        int lat;
        int ndone;

        rst_n = 1'b0;
        s4 = 1'b0; a4 = '0; b4 = '0;
        s32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out4", {busy4, done4, 54'd0, hi4, lo4}, 64'd0);
        check("rst_out32", {busy32, done32, 30'd0, hi32}, 64'd0);
        check("rst_lo32", 64'(lo32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        mul4(4'd3, 4'd5, 4'h0, 4'hF, "w4_3x5");
        mul4(4'd15, 4'd15, 4'hE, 4'h1, "w4_15x15");

        mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "w32_max");
        mul32(32'd0, 32'h1234, 64'd0, "w32_zero");
        mul32(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "w32_carry_hi");

        // Second request during RUN must be dropped.
        @(negedge clk);
        s32 = 1'b1; a32 = 32'd7; b32 = 32'd6;
        @(posedge clk); #1;
        s32 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        s32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
        @(negedge clk);
        s32 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        check("ignore_ndone", 64'(ndone), 64'd1);
        check("ignore_hi", 64'(hi32), 64'd0);
        check("ignore_lo", 64'(lo32), 64'd42);
        check("ignore_idle", 64'(busy32), 64'd0);

        // Start held high across DONE: next operation accepted on the DONE edge.
        @(negedge clk);
        s32 = 1'b1; a32 = 32'd5; b32 = 32'd5;
        @(posedge clk); #1;
        a32 = 32'd100; b32 = 32'd200;
        wait_done32(lat);
        check("b2b_first_latency", 64'(lat), 64'd32);
        check("b2b_first_lo", 64'(lo32), 64'd25);
        @(posedge clk); #1;
        s32 = 1'b0;
        check("b2b_reaccept_busy", 64'(busy32), 64'd1);
        check("b2b_reaccept_done", 64'(done32), 64'd0);
        wait_done32(lat);
        check("b2b_second_latency", 64'(lat), 64'd32);
        check("b2b_second_hi", 64'(hi32), 64'd0);
        check("b2b_second_lo", 64'(lo32), 64'd20000);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        s32 = 1'b1; a32 = 32'd11; b32 = 32'd13;
        @(posedge clk); #1;
        s32 = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy32), 64'd0);
        check("async_rst_hi", 64'(hi32), 64'd0);
        check("async_rst_lo", 64'(lo32), 64'd0);
        check("async_rst_lo4", 64'(lo4), 64'd0);
        ndone = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        check("async_rst_no_done", 64'(ndone), 64'd0);
        mul32(32'd2, 32'd3, 64'd6, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
